// File: rtl/bus_xbar_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bus_xbar_rr                                                |
// | Description : N-host to M-device bus with round-robin arbitration,       |
// |               address decode and in-order response tracking.             |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module bus_xbar_rr #(
    parameter int NrHosts        = 2,
    parameter int NrDevices      = 5,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic [NrHosts-1:0]        host_req_i,
    input  logic [NrHosts-1:0]        host_we_i,
    input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
    output logic [NrHosts-1:0]        host_gnt_o,
    output logic [NrHosts-1:0]        host_rvalid_o,
    output logic [NrHosts-1:0]        host_err_o,
    output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],

    output logic [NrDevices-1:0]      device_req_o,
    output logic [NrDevices-1:0]      device_we_o,
    output logic [AddressWidth-1:0]   device_addr_o [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o   [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o[NrDevices],
    input  logic [NrDevices-1:0]      device_rvalid_i,
    input  logic [NrDevices-1:0]      device_err_i,
    input  logic [DataWidth-1:0]      device_rdata_i[NrDevices],

    input  logic [AddressWidth-1:0]   cfg_device_addr_base[NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask[NrDevices]
);

    localparam int c_HOST_W = (NrHosts > 1)        ? $clog2(NrHosts)        : 1;
    localparam int c_DEV_W  = (NrDevices > 1)      ? $clog2(NrDevices)      : 1;
    localparam int c_PTR_W  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int c_CNT_W  = $clog2(MaxOutstanding) + 1;

    // Arbitration / tracking state
    logic [c_HOST_W-1:0] r_rr;
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_full;

    logic [c_HOST_W-1:0] r_fifo_host [MaxOutstanding];
    logic [c_DEV_W-1:0]  r_fifo_dev  [MaxOutstanding];
    logic                r_fifo_err  [MaxOutstanding];

    logic                w_any_req;
    logic [c_HOST_W-1:0] w_win;
    logic [c_HOST_W:0]   w_cand;
    logic                w_grant;
    logic [AddressWidth-1:0] w_addr;
    logic                w_hit;
    logic [c_DEV_W-1:0]  w_dev;

    logic [c_HOST_W-1:0] w_head_host;
    logic [c_DEV_W-1:0]  w_head_dev;
    logic                w_head_err;
    logic                w_empty;
    logic                w_dev_rvalid;
    logic                w_dev_err;
    logic [DataWidth-1:0] w_dev_rdata;
    logic                w_pop;

    logic [c_CNT_W-1:0]  w_count_nxt;
    logic [c_PTR_W-1:0]  w_wptr_nxt;
    logic [c_PTR_W-1:0]  w_rptr_nxt;
    logic [c_HOST_W-1:0] w_rr_nxt;

    // Walk hosts from the largest offset down so the first requester after r_rr wins.
    always_comb begin
        w_any_req = 1'b0;
        w_win     = '0;
        w_cand    = '0;
        for (int i = NrHosts - 1; i >= 0; i--) begin
            w_cand = {1'b0, r_rr} + (c_HOST_W+1)'(i);
            if (w_cand >= (c_HOST_W+1)'(NrHosts)) begin
                w_cand = w_cand - (c_HOST_W+1)'(NrHosts);
            end
            if (host_req_i[w_cand[c_HOST_W-1:0]]) begin
                w_any_req = 1'b1;
                w_win     = w_cand[c_HOST_W-1:0];
            end
        end
    end

    assign w_grant = w_any_req & ~r_full & ~rst_i;
    assign w_addr  = host_addr_i[w_win];

    // Descending scan: the lowest matching device index overrides the rest.
    always_comb begin
        w_hit = 1'b0;
        w_dev = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((w_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                w_hit = 1'b1;
                w_dev = c_DEV_W'(d);
            end
        end
    end

    always_comb begin
        host_gnt_o = '0;
        if (w_grant) begin
            host_gnt_o[w_win] = 1'b1;
        end
    end

    genvar gd;
    generate
        for (gd = 0; gd < NrDevices; gd++) begin : g_dev_out
            assign device_req_o[gd]   = w_grant & w_hit & (w_dev == c_DEV_W'(gd));
            assign device_we_o[gd]    = host_we_i[w_win];
            assign device_addr_o[gd]  = w_addr;
            assign device_be_o[gd]    = host_be_i[w_win];
            assign device_wdata_o[gd] = host_wdata_i[w_win];
        end
    endgenerate

    assign w_head_host = r_fifo_host[r_rptr];
    assign w_head_dev  = r_fifo_dev[r_rptr];
    assign w_head_err  = r_fifo_err[r_rptr];
    assign w_empty     = (r_count == '0);

    // Only the device owning the head entry may complete; other rvalids are dropped.
    always_comb begin
        w_dev_rvalid = 1'b0;
        w_dev_err    = 1'b0;
        w_dev_rdata  = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (w_head_dev == c_DEV_W'(d)) begin
                w_dev_rvalid = device_rvalid_i[d];
                w_dev_err    = device_err_i[d];
                w_dev_rdata  = device_rdata_i[d];
            end
        end
    end

    assign w_pop = ~rst_i & ~w_empty & (w_head_err | w_dev_rvalid);

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        for (int h = 0; h < NrHosts; h++) begin
            host_rdata_o[h] = '0;
        end
        if (w_pop) begin
            host_rvalid_o[w_head_host] = 1'b1;
            host_err_o[w_head_host]    = w_head_err | w_dev_err;
            host_rdata_o[w_head_host]  = w_head_err ? '0 : w_dev_rdata;
        end
    end

    assign w_count_nxt = r_count + {{(c_CNT_W-1){1'b0}}, w_grant}
                                 - {{(c_CNT_W-1){1'b0}}, w_pop};
    assign w_wptr_nxt  = (r_wptr == c_PTR_W'(MaxOutstanding - 1)) ? '0 : r_wptr + c_PTR_W'(1);
    assign w_rptr_nxt  = (r_rptr == c_PTR_W'(MaxOutstanding - 1)) ? '0 : r_rptr + c_PTR_W'(1);
    assign w_rr_nxt    = (w_win == c_HOST_W'(NrHosts - 1)) ? '0 : w_win + c_HOST_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr    <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_wptr <= w_wptr_nxt;
                r_rr   <= w_rr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            r_count <= w_count_nxt;
            // Registered so a pop while full cannot open a grant in the same cycle.
            r_full  <= (w_count_nxt == c_CNT_W'(MaxOutstanding));
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_fifo_host[r_wptr] <= w_win;
            r_fifo_dev[r_wptr]  <= w_dev;
            r_fifo_err[r_wptr]  <= ~w_hit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_xbar_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bus_xbar_rr                                             |
// | Description : Directed self-checking bench for bus_xbar_rr.              |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_bus_xbar_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  host_req, host_we, host_gnt, host_rvalid, host_err;
    logic [31:0] host_addr  [2];
    logic [3:0]  host_be    [2];
    logic [31:0] host_wdata [2];
    logic [31:0] host_rdata [2];
    logic [4:0]  device_req, device_we, device_rvalid, device_err;
    logic [31:0] device_addr  [5];
    logic [3:0]  device_be    [5];
    logic [31:0] device_wdata [5];
    logic [31:0] device_rdata [5];
    logic [31:0] cfg_base [5];
    logic [31:0] cfg_mask [5];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    bus_xbar_rr #(
        .NrHosts(2), .NrDevices(5), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(4)
    ) u_dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .host_req_i          (host_req),
        .host_we_i           (host_we),
        .host_addr_i         (host_addr),
        .host_be_i           (host_be),
        .host_wdata_i        (host_wdata),
        .host_gnt_o          (host_gnt),
        .host_rvalid_o       (host_rvalid),
        .host_err_o          (host_err),
        .host_rdata_o        (host_rdata),
        .device_req_o        (device_req),
        .device_we_o         (device_we),
        .device_addr_o       (device_addr),
        .device_be_o         (device_be),
        .device_wdata_o      (device_wdata),
        .device_rvalid_i     (device_rvalid),
        .device_err_i        (device_err),
        .device_rdata_i      (device_rdata),
        .cfg_device_addr_base(cfg_base),
        .cfg_device_addr_mask(cfg_mask)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] gnt, input logic [4:0] dreq,
                           input logic [1:0] rv, input logic [1:0] er);
        check_val({tag, ".gnt"},    32'(host_gnt),    32'(gnt));
        check_val({tag, ".dreq"},   32'(device_req),  32'(dreq));
        check_val({tag, ".rvalid"}, 32'(host_rvalid), 32'(rv));
        check_val({tag, ".err"},    32'(host_err),    32'(er));
    endtask

    initial begin
        rst = 1'b1; host_req = '0; host_we = '0; device_rvalid = '0; device_err = '0;
        for (int i = 0; i < 2; i++) begin
            host_addr[i] = '0; host_be[i] = 4'hF; host_wdata[i] = '0;
        end
        for (int d = 0; d < 5; d++) device_rdata[d] = '0;
        // RAM, GPIO, slow device, spare, and a region overlapping RAM
        cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFFF_0000;
        cfg_base[1] = 32'h8000_0000; cfg_mask[1] = 32'hFFFF_F000;
        cfg_base[2] = 32'h2000_0000; cfg_mask[2] = 32'hFFFF_0000;
        cfg_base[3] = 32'h3000_0000; cfg_mask[3] = 32'hFFFF_0000;
        cfg_base[4] = 32'h0010_0000; cfg_mask[4] = 32'hFFFF_F000;

        // Reset held with all hosts requesting and a stray device response
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst = 1'b1; host_req = 2'b11;
            host_addr[0] = 32'h0010_0000; host_addr[1] = 32'h0010_0004;
            device_rvalid = 5'b00001; device_rdata[0] = 32'hDEAD_BEEF;
            #1;
            chk_out("reset", 2'b00, 5'b00000, 2'b00, 2'b00);
            check_val("reset.rdata0", host_rdata[0], 32'h0);
        end

        // Round-robin to RAM, 1-cycle latency
        @(negedge clk);
        rst = 1'b0; device_rvalid = '0; #1;
        chk_out("rr0", 2'b01, 5'b00001, 2'b00, 2'b00);
        check_val("rr0.addr", device_addr[0], 32'h0010_0000);

        @(negedge clk);
        host_addr[0] = 32'h0010_0008; device_rvalid = 5'b00001; device_rdata[0] = 32'h1111_0000; #1;
        chk_out("rr1", 2'b10, 5'b00001, 2'b01, 2'b00);
        check_val("rr1.addr", device_addr[0], 32'h0010_0004);
        check_val("rr1.rdata0", host_rdata[0], 32'h1111_0000);

        @(negedge clk);
        host_addr[1] = 32'h0010_000C; device_rdata[0] = 32'h2222_0001; #1;
        chk_out("rr2", 2'b01, 5'b00001, 2'b10, 2'b00);
        check_val("rr2.rdata1", host_rdata[1], 32'h2222_0001);

        @(negedge clk);
        device_rdata[0] = 32'h3333_0002; #1;
        chk_out("rr3", 2'b10, 5'b00001, 2'b01, 2'b00);
        check_val("rr3.rdata0", host_rdata[0], 32'h3333_0002);

        @(negedge clk);
        host_req = 2'b00; device_rdata[0] = 32'h4444_0003; #1;
        chk_out("rr4", 2'b00, 5'b00000, 2'b10, 2'b00);
        check_val("rr4.rdata1", host_rdata[1], 32'h4444_0003);

        @(negedge clk);
        device_rvalid = '0; #1;
        chk_out("idle", 2'b00, 5'b00000, 2'b00, 2'b00);

        // Decode error: unmapped address
        @(negedge clk);
        host_req = 2'b01; host_addr[0] = 32'h4000_0000; device_rdata[0] = 32'hDEAD_BEEF; #1;
        chk_out("dec0", 2'b01, 5'b00000, 2'b00, 2'b00);

        @(negedge clk);
        host_req = 2'b00; #1;
        chk_out("dec1", 2'b00, 5'b00000, 2'b01, 2'b01);
        check_val("dec1.rdata0", host_rdata[0], 32'h0);

        // Overlap: device 0 and 4 both match, lowest index wins
        @(negedge clk);
        host_req = 2'b10; host_addr[1] = 32'h0010_0010; #1;
        chk_out("ovl0", 2'b10, 5'b00001, 2'b00, 2'b00);

        @(negedge clk);
        host_req = 2'b00; device_rvalid = 5'b00001; device_rdata[0] = 32'h0000_0055; #1;
        chk_out("ovl1", 2'b00, 5'b00000, 2'b10, 2'b00);
        check_val("ovl1.rdata1", host_rdata[1], 32'h0000_0055);

        // Backpressure: slow device withholds rvalid, FIFO fills at 4
        host_addr[0] = 32'h2000_0000; host_addr[1] = 32'h2000_0100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            host_req = 2'b11; device_rvalid = '0; #1;
            chk_out("bp", (i < 4) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b00,
                    (i < 4) ? 5'b00100 : 5'b00000, 2'b00, 2'b00);
        end

        @(negedge clk);
        device_rvalid = 5'b00100; device_rdata[2] = 32'h0000_00A0; #1;
        chk_out("bp_r0", 2'b00, 5'b00000, 2'b01, 2'b00);
        check_val("bp_r0.rdata0", host_rdata[0], 32'h0000_00A0);

        @(negedge clk);
        device_rdata[2] = 32'h0000_00A1; #1;
        chk_out("bp_r1", 2'b01, 5'b00100, 2'b10, 2'b00);
        check_val("bp_r1.rdata1", host_rdata[1], 32'h0000_00A1);

        @(negedge clk);
        host_req = 2'b00; device_rdata[2] = 32'h0000_00A2; #1;
        chk_out("bp_r2", 2'b00, 5'b00000, 2'b01, 2'b00);
        check_val("bp_r2.rdata0", host_rdata[0], 32'h0000_00A2);

        @(negedge clk);
        device_rdata[2] = 32'h0000_00A3; #1;
        chk_out("bp_r3", 2'b00, 5'b00000, 2'b10, 2'b00);
        check_val("bp_r3.rdata1", host_rdata[1], 32'h0000_00A3);

        @(negedge clk);
        device_rdata[2] = 32'h0000_00A4; #1;
        chk_out("bp_r4", 2'b00, 5'b00000, 2'b01, 2'b00);
        check_val("bp_r4.rdata0", host_rdata[0], 32'h0000_00A4);

        @(negedge clk);
        device_rvalid = '0; #1;
        chk_out("bp_end", 2'b00, 5'b00000, 2'b00, 2'b00);

        // Mixed latency: GPIO write queued behind a slow read
        @(negedge clk);
        host_req = 2'b01; host_addr[0] = 32'h2000_0010; host_we = 2'b00; #1;
        chk_out("mix0", 2'b01, 5'b00100, 2'b00, 2'b00);

        @(negedge clk);
        host_req = 2'b10; host_addr[1] = 32'h8000_0004; host_we = 2'b10;
        host_wdata[1] = 32'hCAFE_0001; host_be[1] = 4'b0011; #1;
        chk_out("mix1", 2'b10, 5'b00010, 2'b00, 2'b00);
        check_val("mix1.we", 32'(device_we[1]), 32'h1);
        check_val("mix1.wdata", device_wdata[1], 32'hCAFE_0001);
        check_val("mix1.be", 32'(device_be[1]), 32'h3);

        @(negedge clk);
        host_req = 2'b00; host_we = 2'b00; device_rvalid = 5'b00010; #1;
        chk_out("mix2", 2'b00, 5'b00000, 2'b00, 2'b00);

        @(negedge clk);
        device_rvalid = 5'b00100; device_rdata[2] = 32'h0000_00B2; #1;
        chk_out("mix3", 2'b00, 5'b00000, 2'b01, 2'b00);
        check_val("mix3.rdata0", host_rdata[0], 32'h0000_00B2);

        @(negedge clk);
        device_rvalid = 5'b00010; device_err = 5'b00010; device_rdata[1] = 32'h1234_5678; #1;
        chk_out("mix4", 2'b00, 5'b00000, 2'b10, 2'b10);
        check_val("mix4.rdata1", host_rdata[1], 32'h1234_5678);

        @(negedge clk);
        device_rvalid = '0; device_err = '0; #1;
        chk_out("mix5", 2'b00, 5'b00000, 2'b00, 2'b00);

        // Reset with three transactions in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            host_req = 2'b01; host_addr[0] = 32'h2000_0020; #1;
            chk_out("mid", 2'b01, 5'b00100, 2'b00, 2'b00);
        end

        @(negedge clk);
        rst = 1'b1; host_req = 2'b11; device_rvalid = 5'b00100; #1;
        chk_out("mid_rst", 2'b00, 5'b00000, 2'b00, 2'b00);

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b0; host_req = 2'b00; device_rvalid = 5'b00100; #1;
            chk_out("stale", 2'b00, 5'b00000, 2'b00, 2'b00);
        end

        @(negedge clk);
        device_rvalid = '0; host_req = 2'b11;
        host_addr[0] = 32'h0010_0020; host_addr[1] = 32'h0010_0024; #1;
        chk_out("post0", 2'b01, 5'b00001, 2'b00, 2'b00);

        @(negedge clk);
        host_req = 2'b00; device_rvalid = 5'b00001; device_rdata[0] = 32'h0000_0077; #1;
        chk_out("post1", 2'b00, 5'b00000, 2'b01, 2'b00);
        check_val("post1.rdata0", host_rdata[0], 32'h0000_0077);

        @(negedge clk);
        device_rvalid = '0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
